// File: rtl/pattern101_detector.sv
// pattern101_detector: Moore FSM flagging each overlapping 1-0-1 on in_.
// Ports: clk, reset (async active-low), in_ serial bit, out registered flag.
module pattern101_detector (
   input  logic clk,
   input  logic reset,
   input  logic in_,
   output logic out
);

   typedef enum logic [1:0] {
      A = 2'd0,
      B = 2'd1,
      C = 2'd2,
      D = 2'd3
   } state_t;

   state_t state;

   // out is loaded with the same decision as state, so it always equals
   // (state == D) without any path from in_.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= A;
         out   <= 1'b0;
      end else begin
         unique case (state)
            A: begin
               state <= in_ ? B : A;
               out   <= 1'b0;
            end
            B: begin
               state <= in_ ? B : C;
               out   <= 1'b0;
            end
            C: begin
               state <= in_ ? D : A;
               out   <= in_;
            end
            D: begin
               state <= in_ ? B : C;
               out   <= 1'b0;
            end
            default: begin
               state <= A;
               out   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pattern101_detector.sv
// tb_pattern101_detector: directed and random checks of pattern101_detector
// against a 3-bit input-history model.
module tb_pattern101_detector;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic in_ = 1'b0;
   logic out;

   int n_cmp = 0;
   int n_err = 0;
   int pulses = 0;
   int since = 0;
   logic [2:0] hist = 3'b000;

   pattern101_detector dut (
      .clk   (clk),
      .reset (reset),
      .in_   (in_),
      .out   (out)
   );

   always #5 clk = ~clk;

   // Golden model: the last three bits accepted since reset.
   always @(posedge clk or negedge reset) begin
      if (!reset) hist <= 3'b000;
      else        hist <= {hist[1:0], in_};
   end

   // Clock edges seen since reset was last released (saturating).
   always @(posedge clk or negedge reset) begin
      if (!reset)       since <= 0;
      else if (since < 3) since <= since + 1;
   end

   always @(negedge clk) begin
      n_cmp++;
      if (out !== (hist == 3'b101)) begin
         n_err++;
         $display("FAIL model t=%0t out=%b expected=%b", $time, out,
                  (hist == 3'b101));
      end
      if (!reset || since <= 2) begin
         n_cmp++;
         if (out !== 1'b0) begin
            n_err++;
            $display("FAIL rst_quiet t=%0t out=%b expected=0", $time, out);
         end
      end
      if (out === 1'b1) pulses++;
   end

   task automatic check(input string name, input logic [1:0] act,
                        input logic [1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic b);
      @(negedge clk);
      in_ = b;
   endtask

   task automatic start_count();
      @(negedge clk);
      #1 pulses = 0;
   endtask

   task automatic end_count(input string name, input int exp);
      drive(1'b0);
      @(negedge clk);
      #1;
      check(name, 2'(pulses), 2'(exp));
   endtask

   logic [1:0] st;
   logic [1:0] ws [15] = '{0, 0, 1, 1, 2, 0, 1, 2, 3, 2, 3, 1, 2, 0, 0};
   logic       wi [14] = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0};
   logic       ps [33] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0, 1, 0,
                           0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 1,
                           0, 1, 0, 0, 0};
   logic       rs [9]  = '{0, 1, 1, 0, 0, 1, 0, 1, 0};

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      in_ = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      st = dut.state;
      check("reset_state", st, 2'd0);
      check("reset_out", {1'b0, out}, 2'd0);
      @(negedge clk);
      reset = 1'b1;

      // Directed walk with hand-computed states.
      for (int i = 0; i < 14; i++) begin
         drive(wi[i]);
         @(posedge clk);
         #1;
         st = dut.state;
         check($sformatf("walk_state%0d", i), st, ws[i+1]);
         check($sformatf("walk_out%0d", i), {1'b0, out},
               {1'b0, ws[i+1] == 2'd3});
      end

      // Embedded patterns, including overlaps: six pulses.
      start_count();
      for (int i = 0; i < 33; i++) drive(ps[i]);
      end_count("pattern_pulses", 6);

      // Reset mid-stream discards history.
      start_count();
      for (int i = 0; i < 9; i++) drive(rs[i]);
      end_count("mid_seq1", 1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      st = dut.state;
      check("mid_rst_state", st, 2'd0);
      check("mid_rst_out", {1'b0, out}, 2'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      start_count();
      for (int i = 0; i < 9; i++) drive(rs[i]);
      end_count("mid_seq2", 1);

      // Asynchronous reset while in D.
      drive(1'b1);
      drive(1'b0);
      drive(1'b1);
      @(posedge clk);
      #1;
      check("async_d_out", {1'b0, out}, 2'd1);
      #2 reset = 1'b0;
      #1;
      check("async_out", {1'b0, out}, 2'd0);
      st = dut.state;
      check("async_state", st, 2'd0);
      @(negedge clk);
      reset = 1'b1;

      // Random data, checked by the model every cycle.
      for (int i = 0; i < 40; i++) drive(1'($urandom_range(0, 1)));

      // Random reset and data.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 3) != 0);
         in_ = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (4) drive(1'b0);
      @(negedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
